// File: rtl/spad_multi_port.sv
// spad_multi_port: scratchpad memory with one write port and NUM_RD
// independent synchronous read ports. Same-cycle read/write to one address
// returns the new data. A clear FSM fills the memory with INIT_VALUE after
// reset or on init_req. User traffic is accepted only while the FSM is idle.
module spad_multi_port #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int NUM_RD        = 2,
  parameter int READ_LATENCY  = 1,
  parameter logic [DATA_BITWIDTH-1:0] INIT_VALUE = '0,
  parameter logic [DATA_BITWIDTH-1:0] IDLE_VALUE = DATA_BITWIDTH'(10101)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              init_req,
  output logic                              init_busy,
  input  logic [NUM_RD-1:0]                 rd_req,
  input  logic [NUM_RD*ADDR_BITWIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_BITWIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]                 rd_valid,
  input  logic                              wr_en,
  input  logic [ADDR_BITWIDTH-1:0]          wr_addr,
  input  logic [DATA_BITWIDTH-1:0]          wr_data
);

  localparam int DEPTH = 1 << ADDR_BITWIDTH;
  localparam int CNT_W = ADDR_BITWIDTH + 1;

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("spad_multi_port: READ_LATENCY must be 1 or 2");
  end
  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_ports
    $error("spad_multi_port: NUM_RD must be in 1..4");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [DATA_BITWIDTH-1:0]  mem [DEPTH];
  logic                      user_ok;
  logic [NUM_RD-1:0]         rd_hit;

  logic [NUM_RD-1:0]         vld_p0;
  logic [DATA_BITWIDTH-1:0]  data_p0 [NUM_RD];
  logic [NUM_RD-1:0]         vld_out;
  logic [DATA_BITWIDTH-1:0]  data_out [NUM_RD];

  assign init_busy = (state == CLEAR);
  assign user_ok   = (state == IDLE) && !reset;

  // FSM state and sweep counter register; reset restarts the sweep at 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: IDLE waits for init_req, CLEAR walks every address once
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (init_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory write: the sweep owns the port during CLEAR, the user otherwise
  always_ff @(posedge clk) begin
    if ((state == CLEAR) && !reset) begin
      mem[cnt[ADDR_BITWIDTH-1:0]] <= INIT_VALUE;
    end else if (user_ok && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port write-first detection against the write port
  always_comb begin
    rd_hit = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_hit[i] = wr_en && (wr_addr == rd_addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH]);
    end
  end

  // ---- stage p0: array read with write-first bypass ----
  // Read data capture; not reset because rd_data is masked by valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      data_p0[i] <= rd_hit[i] ? wr_data
                              : mem[rd_addr[i*ADDR_BITWIDTH +: ADDR_BITWIDTH]];
    end
  end

  // Valid capture: requests count only while the FSM is idle
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= '0;
    else       vld_p0 <= rd_req & {NUM_RD{user_ok}};
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [NUM_RD-1:0]        vld_p1;
    logic [DATA_BITWIDTH-1:0] data_p1 [NUM_RD];

    // ---- stage p1: extra output register ----
    // Data delay register
    always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RD; i++) data_p1[i] <= data_p0[i];
    end

    // Valid delay register, flushed by reset
    always_ff @(posedge clk) begin
      if (reset) vld_p1 <= '0;
      else       vld_p1 <= vld_p0;
    end

    assign vld_out  = vld_p1;
    assign data_out = data_p1;
  end else begin : g_lat1
    assign vld_out  = vld_p0;
    assign data_out = data_p0;
  end

  // ---- output: idle ports drive IDLE_VALUE ----
  // Output mux keeps rd_data defined whenever valid is low
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_BITWIDTH +: DATA_BITWIDTH] = vld_out[i] ? data_out[i] : IDLE_VALUE;
    end
  end

  assign rd_valid = vld_out;

endmodule

// File: tb/tb_spad_multi_port.sv
// Testbench for spad_multi_port: latency-1 and latency-2 instances share one
// stimulus stream; a scoreboard queue per (instance, port) holds the expected
// word and the cycle it must appear, and a monitor checks every cycle.
module tb_spad_multi_port;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam logic [DW-1:0] IDLE_V = 16'd10101;

  logic            clk = 1'b0;
  logic            reset, init_req, wr_en;
  logic [NR-1:0]   rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy1, busy2;
  logic [NR*DW-1:0] rdata1, rdata2;
  logic [NR-1:0]   rvld1, rvld2;

  always #5 clk = ~clk;

  spad_multi_port #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_RD(NR),
                    .READ_LATENCY(1), .INIT_VALUE('0), .IDLE_VALUE(IDLE_V)) u_l1 (
    .clk(clk), .reset(reset), .init_req(init_req), .init_busy(busy1),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdata1), .rd_valid(rvld1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  spad_multi_port #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_RD(NR),
                    .READ_LATENCY(2), .INIT_VALUE('0), .IDLE_VALUE(IDLE_V)) u_l2 (
    .clk(clk), .reset(reset), .init_req(init_req), .init_busy(busy2),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rdata2), .rd_valid(rvld2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  // lanes 0,1: latency-1 ports 0,1; lanes 2,3: latency-2 ports 0,1
  exp_t          sb [4][$];
  logic [DW-1:0] model [16];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  int            c1, c2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle each lane must show exactly what the scoreboard says
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int l = 0; l < 4; l++) begin
          logic          v;
          logic [DW-1:0] d;
          logic          have;
          logic [DW-1:0] ed;
          v  = (l < 2) ? rvld1[l] : rvld2[l-2];
          d  = (l < 2) ? rdata1[l*DW +: DW] : rdata2[(l-2)*DW +: DW];
          have = 1'b0;
          ed   = IDLE_V;
          if (sb[l].size() > 0 && sb[l][0].due == cyc) begin
            have = 1'b1;
            ed   = sb[l][0].data;
            void'(sb[l].pop_front());
          end
          chk($sformatf("rd_valid lane%0d", l), 32'(v), 32'(have));
          chk($sformatf("rd_data lane%0d", l), 32'(d), 32'(ed));
        end
      end
    end
  end

  // Drive one cycle of inputs; when acc is set the FSM is idle and the
  // expected read results are pushed and the write is applied to the model.
  task automatic drive(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] rq, input logic [3:0] a0, input logic [3:0] a1,
                       input bit ini, input bit acc);
    logic [3:0] ra [2];
    exp_t e;
    ra[0] = a0;
    ra[1] = a1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_addr = {a1, a0}; init_req = ini;
    if (acc) begin
      for (int p = 0; p < 2; p++) begin
        if (rq[p]) begin
          e.data = (we && wa == ra[p]) ? wd : model[ra[p]];
          e.due  = cyc + 1;
          sb[p].push_back(e);
          e.due  = cyc + 2;
          sb[2+p].push_back(e);
        end
      end
      if (we) model[wa] = wd;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic clear_model();
    for (int a = 0; a < 16; a++) model[a] = '0;
  endtask

  // Count busy cycles of both instances; optionally hammer the ports meanwhile
  task automatic count_busy(input bit poke, output int n1, output int n2);
    n1 = 0;
    n2 = 0;
    for (int k = 0; k < 40 && (busy1 || busy2); k++) begin
      if (busy1) n1++;
      if (busy2) n2++;
      if (poke) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1111;
        rd_req = 2'b11; rd_addr = {4'd3, 4'd3}; init_req = (k == 5);
      end
      @(negedge clk);
    end
    wr_en = 1'b0; rd_req = '0; init_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; init_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_addr = '0;
    clear_model();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    chk("reset busy l1", 32'(busy1), 32'd1);
    chk("reset busy l2", 32'(busy2), 32'd1);
    reset = 1'b0;

    // Power-up sweep length
    count_busy(1'b0, c1, c2);
    chk("sweep len l1", 32'(c1), 32'd16);
    chk("sweep len l2", 32'(c2), 32'd16);
    chk("idle after sweep", 32'(busy1), 32'd0);

    // Every location reads INIT_VALUE on both ports
    for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 16'h0, 2'b11, 4'(i), 4'(i), 1'b0, 1'b1);
    idle(3);

    // Basic write then read
    drive(1'b1, 4'd5, 16'h1234, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 16'h0, 2'b01, 4'd5, 4'd0, 1'b0, 1'b1);
    idle(3);

    // Write-first bypass on port 1, port 0 unaffected on a neighbour
    drive(1'b1, 4'd7, 16'h00AA, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 4'd6, 16'h0066, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 4'd7, 16'h5555, 2'b11, 4'd6, 4'd7, 1'b0, 1'b1);
    drive(1'b1, 4'd9, 16'h9999, 2'b11, 4'd9, 4'd7, 1'b0, 1'b1);
    idle(3);

    // Fill with distinct words, then stream both ports in opposite order
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      drive(1'b1, a, {4'hC, a, ~a, a}, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 16'h0, 2'b11, 4'(i), 4'(15 - i), 1'b0, 1'b1);
    idle(3);

    // init_req with a read in the same (last idle) cycle; traffic ignored while busy
    drive(1'b1, 4'd3, 16'hBEEF, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 16'h0, 2'b01, 4'd3, 4'd0, 1'b1, 1'b1);
    clear_model();
    chk("busy after init_req", 32'(busy1), 32'd1);
    count_busy(1'b1, c1, c2);
    chk("init sweep len l1", 32'(c1), 32'd16);
    chk("init sweep len l2", 32'(c2), 32'd16);
    drive(1'b0, 4'd0, 16'h0, 2'b11, 4'd3, 4'd15, 1'b0, 1'b1);
    idle(3);

    // Reset at sweep count 9 restarts a full sweep
    drive(1'b1, 4'd12, 16'h7777, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 1'b1, 1'b1);
    init_req = 1'b0;
    clear_model();
    repeat (9) @(negedge clk);
    chk("busy mid sweep", 32'(busy1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(1'b0, c1, c2);
    chk("restart sweep len l1", 32'(c1), 32'd16);
    chk("restart sweep len l2", 32'(c2), 32'd16);
    drive(1'b0, 4'd0, 16'h0, 2'b11, 4'd12, 4'd9, 1'b0, 1'b1);
    drive(1'b1, 4'd2, 16'hABCD, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 16'h0, 2'b11, 4'd2, 4'd2, 1'b0, 1'b1);
    idle(4);

    for (int l = 0; l < 4; l++) chk($sformatf("drained lane%0d", l), 32'(sb[l].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
